xc_malu_arbiter: RTL and testbench

//  Shares one xc_malu instance between two requesters: port 0 is the core

---
 rtl/xc_malu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_xc_malu_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_arbiter.sv
// xc_malu_arbiter: shares one xc_malu between requester 0 (core execute
// stage) and requester 1 (coprocessor issue queue). Round-robin grant,
// operands held in local registers while the unit works, 64-bit result
// returned over a valid/ready handshake, and a one-cycle flush after every
// operation so no operand residue crosses requesters.
// Optional build macro: XC_MALU_ARB_LFSR_EN (LFSR-driven flush data).
module xc_malu_arbiter #(
  parameter int unsigned UOP_W     = 14,
  parameter int unsigned PW_W      = 5,
  parameter logic [31:0] LFSR_SEED = 32'h6A09E667
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_kill,
  input  logic [2*UOP_W-1:0] req_uop,
  input  logic [2*PW_W-1:0]  req_pw,
  input  logic [63:0]        req_rs1,
  input  logic [63:0]        req_rs2,
  input  logic [63:0]        req_rs3,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [63:0]        resp_result,
  output logic               resp_err,
  output logic               m_valid,
  output logic [UOP_W-1:0]   m_uop,
  output logic [PW_W-1:0]    m_pw,
  output logic [31:0]        m_rs1,
  output logic [31:0]        m_rs2,
  output logic [31:0]        m_rs3,
  output logic               m_flush,
  output logic [31:0]        m_flush_data,
  input  logic [63:0]        m_result,
  input  logic               m_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, FLUSH} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_rr_ptr;
  logic               r_gnt;
  logic [UOP_W-1:0]   r_uop;
  logic [PW_W-1:0]    r_pw;
  logic [31:0]        r_rs1;
  logic [31:0]        r_rs2;
  logic [31:0]        r_rs3;
  logic [63:0]        r_result;
  logic               r_err;

  logic               w_any;
  logic               w_gnt;
  logic               w_kill;
  logic               w_zero_uop;
  logic [UOP_W-1:0]   w_sel_uop;
  logic [PW_W-1:0]    w_sel_pw;
  logic [31:0]        w_sel_rs1;
  logic [31:0]        w_sel_rs2;
  logic [31:0]        w_sel_rs3;

  // Favoured requester wins if valid, otherwise the other one.
  assign w_any      = |req_valid;
  assign w_gnt      = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_kill     = req_kill[r_gnt];
  assign w_sel_uop  = w_gnt ? req_uop[2*UOP_W-1:UOP_W] : req_uop[UOP_W-1:0];
  assign w_sel_pw   = w_gnt ? req_pw[2*PW_W-1:PW_W]    : req_pw[PW_W-1:0];
  assign w_sel_rs1  = w_gnt ? req_rs1[63:32] : req_rs1[31:0];
  assign w_sel_rs2  = w_gnt ? req_rs2[63:32] : req_rs2[31:0];
  assign w_sel_rs3  = w_gnt ? req_rs3[63:32] : req_rs3[31:0];
  assign w_zero_uop = (w_sel_uop == '0);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; kill outranks a same-cycle m_ready or resp_ready.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_any) w_next = w_zero_uop ? RESP : BUSY;
      BUSY:  if (w_kill) w_next = FLUSH;
             else if (m_ready) w_next = RESP;
      RESP:  if (w_kill || resp_ready[r_gnt]) w_next = FLUSH;
      FLUSH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant bookkeeping, operand latch, result capture and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rr_ptr <= 1'b0;
      r_gnt    <= 1'b0;
      r_uop    <= '0;
      r_pw     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rs3    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt    <= w_gnt;
          r_uop    <= w_sel_uop;
          r_pw     <= w_sel_pw;
          r_rs1    <= w_sel_rs1;
          r_rs2    <= w_sel_rs2;
          r_rs3    <= w_sel_rs3;
          r_result <= '0;
          r_err    <= w_zero_uop;
        end
        BUSY:  if (!w_kill && m_ready) r_result <= m_result;
        FLUSH: r_rr_ptr <= ~r_gnt;
        default: ;
      endcase
    end
  end

  // Handshake and unit-control outputs decoded from the current state.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_err   = 1'b0;
    m_valid    = 1'b0;
    m_flush    = 1'b0;
    case (r_state)
      IDLE:  if (resetn && w_any) req_ready[w_gnt] = 1'b1;
      BUSY:  m_valid = 1'b1;
      RESP:  begin
        resp_valid[r_gnt] = 1'b1;
        resp_err          = r_err;
      end
      FLUSH: m_flush = 1'b1;
      default: ;
    endcase
  end

  assign m_uop       = r_uop;
  assign m_pw        = r_pw;
  assign m_rs1       = r_rs1;
  assign m_rs2       = r_rs2;
  assign m_rs3       = r_rs3;
  assign resp_result = r_result;

`ifdef XC_MALU_ARB_LFSR_EN
  logic [31:0] r_lfsr;

  // Galois LFSR, taps 32,22,2,1, stepping every cycle to scrub the unit.
  always_ff @(posedge clock) begin
    if (!resetn) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  assign m_flush_data = r_lfsr;
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign m_flush_data  = '0;
`endif

endmodule

// File: tb/tb_xc_malu_arbiter.sv
// Testbench for xc_malu_arbiter: a behavioural xc_malu stub, requester
// agents, a transaction-level reference model checked every cycle, and
// directed scenarios with hand-computed results.
module tb_xc_malu_arbiter;
  localparam int unsigned UOP_W = 14;
  localparam int unsigned PW_W  = 5;
  localparam logic [UOP_W-1:0] UOP_DIV = 14'b00_0000_0000_0001;
  localparam logic [UOP_W-1:0] UOP_MUL = 14'b00_0000_0001_0000;
  localparam int LAT = 3;

  logic clock = 1'b0;
  logic resetn;
  logic [1:0] req_valid, req_ready, req_kill, resp_valid, resp_ready;
  logic [2*UOP_W-1:0] req_uop;
  logic [2*PW_W-1:0]  req_pw;
  logic [63:0] req_rs1, req_rs2, req_rs3, resp_result, m_result;
  logic resp_err, m_valid, m_flush, m_ready;
  logic [UOP_W-1:0] m_uop;
  logic [PW_W-1:0]  m_pw;
  logic [31:0] m_rs1, m_rs2, m_rs3, m_flush_data;

  xc_malu_arbiter #(.UOP_W(UOP_W), .PW_W(PW_W), .LFSR_SEED(32'h6A09E667)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_kill(req_kill),
    .req_uop(req_uop), .req_pw(req_pw),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .m_valid(m_valid), .m_uop(m_uop), .m_pw(m_pw),
    .m_rs1(m_rs1), .m_rs2(m_rs2), .m_rs3(m_rs3),
    .m_flush(m_flush), .m_flush_data(m_flush_data),
    .m_result(m_result), .m_ready(m_ready)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the unit computes for the two uops the bench uses.
  function automatic logic [63:0] golden(input logic [UOP_W-1:0] uop,
                                         input logic [31:0] a, input logic [31:0] b);
    if (uop == UOP_MUL) return {32'b0, a} * {32'b0, b};
    if (uop == UOP_DIV && b != 32'd0) return {32'b0, a / b};
    return 64'd0;
  endfunction

  // xc_malu stand-in: ready after LAT cycles of m_valid, never on the first.
  initial begin
    int mcnt;
    mcnt = 0; m_ready = 1'b0; m_result = '0;
    forever begin
      @(posedge clock); #1;
      if (m_valid === 1'b1) begin
        mcnt++;
        m_ready  = (mcnt >= LAT);
        m_result = golden(m_uop, m_rs1, m_rs2);
      end else begin
        mcnt = 0;
        m_ready = 1'b0;
      end
    end
  end

  // Requester agents: drop req_valid after acceptance; log grants/responses.
  int grants[$];
  int rs_who[$];
  logic [63:0] rs_res[$];
  logic rs_err[$];
  int mvalid_cycles = 0;
  int flush_cycles = 0;
  initial begin
    logic [1:0] rr_seen;
    forever begin
      @(negedge clock);
      rr_seen = req_ready;
      if (m_valid === 1'b1) mvalid_cycles++;
      if (m_flush === 1'b1) flush_cycles++;
      for (int i = 0; i < 2; i++)
        if (resp_valid[i] === 1'b1 && resp_ready[i] === 1'b1) begin
          rs_who.push_back(i); rs_res.push_back(resp_result); rs_err.push_back(resp_err);
        end
      @(posedge clock); #1;
      for (int i = 0; i < 2; i++)
        if (rr_seen[i] === 1'b1) begin
          req_valid[i] = 1'b0;
          grants.push_back(i);
        end
    end
  end

  // Reference model: one transaction in flight, its owner, and the answer
  // the owner must receive, derived from the operands it sent.
  typedef enum {M_FREE, M_WORKING, M_ANSWER, M_SCRUB} mph_t;
  mph_t mph = M_FREE;
  int m_owner = 0;
  int m_prefer = 0;
  logic [UOP_W-1:0] t_uop;
  logic [PW_W-1:0]  t_pw;
  logic [31:0] t_rs1, t_rs2, t_rs3;
  logic [63:0] t_res;
  logic t_err;

  function automatic int pick();
    if (req_valid[m_prefer] === 1'b1) return m_prefer;
    return 1 - m_prefer;
  endfunction

  initial begin
    int g;
    forever begin
      @(posedge clock);
      if (resetn !== 1'b1) begin
        mph = M_FREE; m_prefer = 0;
      end else begin
        case (mph)
          M_FREE: if (|req_valid) begin
            g = pick();
            m_owner = g;
            t_uop = req_uop[g*UOP_W +: UOP_W];
            t_pw  = req_pw[g*PW_W +: PW_W];
            t_rs1 = req_rs1[g*32 +: 32];
            t_rs2 = req_rs2[g*32 +: 32];
            t_rs3 = req_rs3[g*32 +: 32];
            t_err = (t_uop == '0);
            t_res = t_err ? 64'd0 : golden(t_uop, t_rs1, t_rs2);
            mph   = t_err ? M_ANSWER : M_WORKING;
          end
          M_WORKING: if (req_kill[m_owner]) mph = M_SCRUB;
                     else if (m_ready) mph = M_ANSWER;
          M_ANSWER:  if (req_kill[m_owner] || resp_ready[m_owner]) mph = M_SCRUB;
          M_SCRUB:   begin m_prefer = 1 - m_owner; mph = M_FREE; end
          default:   mph = M_FREE;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [1:0] exp_rr, exp_rv;
    @(posedge clock);
    forever begin
      @(negedge clock);
      exp_rr = '0;
      if (resetn === 1'b1 && mph == M_FREE && |req_valid) exp_rr[pick()] = 1'b1;
      exp_rv = '0;
      if (mph == M_ANSWER) exp_rv[m_owner] = 1'b1;
      chk("req_ready", req_ready, exp_rr);
      chk("resp_valid", resp_valid, exp_rv);
      chk("m_valid", m_valid, mph == M_WORKING);
      chk("m_flush", m_flush, mph == M_SCRUB);
      if (mph == M_WORKING) begin
        chk("m_uop", m_uop, t_uop);
        chk("m_pw", m_pw, t_pw);
        chk("m_rs1", m_rs1, t_rs1);
        chk("m_rs2", m_rs2, t_rs2);
        chk("m_rs3", m_rs3, t_rs3);
      end
      if (mph == M_ANSWER) begin
        chk("resp_result", resp_result, t_res);
        chk("resp_err", resp_err, t_err);
      end
`ifndef XC_MALU_ARB_LFSR_EN
      chk("m_flush_data", m_flush_data, 64'd0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int r, input logic [UOP_W-1:0] uop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [PW_W-1:0] pw);
    req_uop[r*UOP_W +: UOP_W] = uop;
    req_pw[r*PW_W +: PW_W]    = pw;
    req_rs1[r*32 +: 32] = a;
    req_rs2[r*32 +: 32] = b;
    req_rs3[r*32 +: 32] = c;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while (!(mph == M_FREE && req_valid == 2'b00) && k < 60) begin tick(1); k++; end
    chk("quiet_timeout", k < 60, 1);
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (grants.size() < n && k < 40) begin tick(1); k++; end
    chk("grant_timeout", grants.size(), n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_flush"}, m_flush, 0);
    chk({tag, "_resp_result"}, resp_result, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_m_rs1"}, m_rs1, 0);
`ifdef XC_MALU_ARB_LFSR_EN
    chk({tag, "_flush_data_nonzero"}, m_flush_data != 32'd0, 1);
`else
    chk({tag, "_flush_data"}, m_flush_data, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int gb, rb, mvb;
    resetn = 1'b0; req_valid = '0; req_kill = '0; req_uop = '0; req_pw = '0;
    req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; resp_ready = 2'b11;
    tick(2);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    tick(1);

    // 1: single multiply, m_valid one cycle after req_ready, one flush.
    set_req(0, UOP_MUL, 32'd7, 32'd6, 32'd1, 5'b00001);
    @(negedge clock);
    chk("t1_req_ready", req_ready, 2'b01);
    chk("t1_m_valid_pre", m_valid, 0);
    @(negedge clock);
    chk("t1_m_valid", m_valid, 1);
    wait_quiet();
    chk("t1_resp_count", rs_who.size(), 1);
    chk("t1_result", rs_res[0], 64'd42);
    chk("t1_who", rs_who[0], 0);
    chk("t1_flushes", flush_cycles, 1);

    // 2: reset state, simultaneous requests, strict alternation.
    resetn = 1'b0; tick(1); resetn = 1'b1;
    gb = grants.size(); rb = rs_res.size();
    set_req(0, UOP_MUL, 32'd2, 32'd3, 32'd0, 5'b00010);
    set_req(1, UOP_MUL, 32'd4, 32'd5, 32'd0, 5'b00100);
    wait_quiet();
    set_req(0, UOP_MUL, 32'd6, 32'd7, 32'd0, 5'b01000);
    set_req(1, UOP_MUL, 32'd8, 32'd9, 32'd0, 5'b10000);
    wait_quiet();
    chk("t2_grant_count", grants.size(), gb + 4);
    chk("t2_g0", grants[gb], 0);
    chk("t2_g1", grants[gb+1], 1);
    chk("t2_g2", grants[gb+2], 0);
    chk("t2_g3", grants[gb+3], 1);
    chk("t2_r0", rs_res[rb], 64'd6);
    chk("t2_r1", rs_res[rb+1], 64'd20);
    chk("t2_r2", rs_res[rb+2], 64'd42);
    chk("t2_r3", rs_res[rb+3], 64'd72);

    // 3: response held for 5 cycles while requester 0 waits.
    rb = rs_res.size(); gb = grants.size();
    resp_ready = 2'b01;
    set_req(1, UOP_DIV, 32'd100, 32'd7, 32'd0, 5'b00001);
    begin
      int k;
      k = 0;
      while (resp_valid[1] !== 1'b1 && k < 40) begin tick(1); k++; end
    end
    chk("t3_resp_seen", resp_valid, 2'b10);
    set_req(0, UOP_MUL, 32'd3, 32'd5, 32'd0, 5'b00001);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t3_hold_valid", resp_valid, 2'b10);
      chk("t3_hold_result", resp_result, 64'd14);
      chk("t3_no_grant", req_ready, 2'b00);
    end
    chk("t3_grants_frozen", grants.size(), gb + 1);
    resp_ready = 2'b11;
    wait_quiet();
    chk("t3_r_div", rs_res[rb], 64'd14);
    chk("t3_r_mul", rs_res[rb+1], 64'd15);
    chk("t3_who", rs_who[rb+1], 0);

    // 4: kill requester 0 mid-BUSY; requester 1 then served, stray kill ignored.
    rb = rs_res.size(); gb = grants.size();
    set_req(0, UOP_MUL, 32'd11, 32'd11, 32'd0, 5'b00001);
    wait_grants(gb + 1);
    set_req(1, UOP_MUL, 32'd9, 32'd9, 32'd0, 5'b00001);
    req_kill = 2'b01;
    tick(1);
    req_kill = 2'b00;
    chk("t4_flush", m_flush, 1);
    chk("t4_no_resp", resp_valid, 0);
    wait_grants(gb + 2);
    req_kill = 2'b01;
    tick(2);
    req_kill = 2'b00;
    wait_quiet();
    chk("t4_resp_count", rs_res.size(), rb + 1);
    chk("t4_who", rs_who[rb], 1);
    chk("t4_result", rs_res[rb], 64'd81);

    // 5: all-zero uop answered with an error, unit never driven.
    rb = rs_res.size(); mvb = mvalid_cycles;
    set_req(0, '0, 32'd5, 32'd5, 32'd5, 5'b00001);
    wait_quiet();
    chk("t5_resp_count", rs_res.size(), rb + 1);
    chk("t5_err", rs_err[rb], 1);
    chk("t5_result", rs_res[rb], 64'd0);
    chk("t5_no_m_valid", mvalid_cycles, mvb);

    // 6: reset during BUSY abandons the op and restores requester-0 priority.
    rb = rs_res.size(); gb = grants.size();
    set_req(1, UOP_MUL, 32'd12, 32'd12, 32'd0, 5'b00001);
    wait_grants(gb + 1);
    tick(1);
    chk("t6_busy", m_valid, 1);
    resetn = 1'b0;
    tick(1);
    chk_reset_outputs("t6");
    resetn = 1'b1;
    set_req(0, UOP_MUL, 32'd1, 32'd2, 32'd0, 5'b00001);
    set_req(1, UOP_MUL, 32'd3, 32'd4, 32'd0, 5'b00001);
    wait_quiet();
    chk("t6_first_grant", grants[gb+1], 0);
    chk("t6_resp_count", rs_res.size(), rb + 2);
    chk("t6_r0", rs_res[rb], 64'd2);
    chk("t6_r1", rs_res[rb+1], 64'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
